// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the 6502 memory arbiter.
// Holds the arbiter state and owner enums plus the address map defaults.
package mem_arbiter_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam logic [15:0] VEC_BASE = 16'hFFF0;
  localparam int VEC_SIZE = 16;
  localparam int LOW_WORDS_DEFAULT = 3840;
  localparam int AW_DEFAULT = 13;

endpackage

// File: rtl/mem_addr_map.sv
// Folds a sparse 16-bit 6502 address into the compact RAM index.
// Ports: addr in; mapped (address hits RAM), index (RAM word) out.
module mem_addr_map
  import mem_arbiter_pkg::*;
#(
  parameter int LOW_WORDS = LOW_WORDS_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic [15:0]   addr,
  output logic          mapped,
  output logic [AW-1:0] index
);

  localparam logic [15:0] LOW_LIM = 16'(LOW_WORDS);
  localparam logic [AW-1:0] VEC_OFF = AW'(LOW_WORDS);

  logic [15:0] vec_rel;

  assign vec_rel = addr - VEC_BASE;

  // The vector window sits right after the low window in RAM.
  always_comb begin
    mapped = 1'b0;
    index  = '0;
    unique case (1'b1)
      (addr < LOW_LIM): begin
        mapped = 1'b1;
        index  = addr[AW-1:0];
      end
      (addr >= VEC_BASE): begin
        mapped = 1'b1;
        index  = VEC_OFF + AW'(vec_rel);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the 6502 bus and a debug/loader port.
// Ports: cpu_* bus, dbg_* loader, dbg_halt/halted/cpu_rdy, mem_* RAM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LOW_WORDS = LOW_WORDS_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_rdy,
  input  logic          dbg_halt,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [15:0]   dbg_addr,
  input  logic [7:0]    dbg_wdata,
  output logic          dbg_ack,
  output logic [7:0]    dbg_rdata,
  output logic          halted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  state_t  state;
  owner_t  p1_owner;
  logic    p1_valid;
  logic    p1_we;
  logic    p1_mapped;

  logic    dbg_inflight;
  logic    dbg_busy;
  logic    cpu_grant;
  logic    dbg_grant;
  logic    any_grant;
  logic    sel_we;
  logic    sel_mapped;
  logic [15:0]   sel_addr;
  logic [7:0]    sel_wdata;
  logic [AW-1:0] sel_index;
  logic [7:0]    rd_data;

  // A debug access blocks new issues until its ack cycle has passed.
  assign dbg_inflight = p1_valid && (p1_owner == OWN_DBG);
  assign dbg_busy     = dbg_inflight || dbg_ack;

  assign cpu_grant = cpu_req && (state == ST_RUN) && !reset;
  assign dbg_grant = dbg_req && !dbg_busy && !cpu_grant && !reset;
  assign any_grant = cpu_grant || dbg_grant;

  assign sel_addr  = cpu_grant ? cpu_addr  : dbg_addr;
  assign sel_wdata = cpu_grant ? cpu_wdata : dbg_wdata;
  assign sel_we    = cpu_grant ? cpu_we    : dbg_we;

  mem_addr_map #(
    .LOW_WORDS (LOW_WORDS),
    .AW        (AW)
  ) u_map (
    .addr   (sel_addr),
    .mapped (sel_mapped),
    .index  (sel_index)
  );

  assign mem_en    = any_grant && sel_mapped;
  assign mem_we    = mem_en && sel_we;
  assign mem_addr  = sel_index;
  assign mem_wdata = sel_wdata;

  // Unmapped reads still complete, returning zero.
  assign rd_data = p1_mapped ? mem_rdata : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      halted  <= 1'b0;
      cpu_rdy <= 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (dbg_halt) begin
            state   <= ST_HALTED;
            halted  <= 1'b1;
            cpu_rdy <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (!dbg_halt && !dbg_grant && !dbg_inflight) begin
            state   <= ST_RUN;
            halted  <= 1'b0;
            cpu_rdy <= 1'b1;
          end
        end
        default: begin
          state   <= ST_RUN;
          halted  <= 1'b0;
          cpu_rdy <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid  <= 1'b0;
      p1_we     <= 1'b0;
      p1_mapped <= 1'b0;
      p1_owner  <= OWN_CPU;
      dbg_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      dbg_rdata <= 8'h00;
    end else begin
      p1_valid  <= any_grant;
      p1_we     <= sel_we;
      p1_mapped <= sel_mapped;
      p1_owner  <= dbg_grant ? OWN_DBG : OWN_CPU;
      dbg_ack   <= dbg_inflight;
      if (p1_valid && !p1_we) begin
        if (p1_owner == OWN_DBG) begin
          dbg_rdata <= rd_data;
        end else begin
          cpu_rdata <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Models the synchronous RAM and walks the main access scenarios.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        dbg_halt = 1'b0;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [15:0] dbg_addr = 16'h0;
  logic [7:0]  dbg_wdata = 8'h0;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;
  logic        halted;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h0;

  logic [7:0]  ram [0:8191];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .dbg_halt  (dbg_halt),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .halted    (halted),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] v);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    cpu_req = 1'b0;
    tick();
    v = cpu_rdata;
  endtask

  task automatic dbg_read(input logic [15:0] a, output logic [7:0] v,
                          output logic ack);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
    tick();
    tick();
    v = dbg_rdata;
    ack = dbg_ack;
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005;
    tick();
    tick();
    settle();
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mem_en: got %b want 0", mem_en);
    end
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mem_we: got %b want 0", mem_we);
    end
    vectors++;
    if (cpu_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata);
    end
    vectors++;
    if (dbg_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_dbg_rdata: got %h want 00", dbg_rdata);
    end
    vectors++;
    if (dbg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_dbg_ack: got %b want 0", dbg_ack);
    end
    vectors++;
    if (cpu_rdy !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_state: got rdy=%b halted=%b want 1/0",
               cpu_rdy, halted);
    end
    reset = 1'b0;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_cpu_rw();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'h010) begin
      miscompares++;
      $display("FAIL cpu_wr_port: got en=%b we=%b addr=%h want 1/1/010",
               mem_en, mem_we, mem_addr);
    end
    tick();
    cpu_we = 1'b0;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 13'h010) begin
      miscompares++;
      $display("FAIL cpu_rd_port: got en=%b we=%b addr=%h want 1/0/010",
               mem_en, mem_we, mem_addr);
    end
    tick();
    cpu_req = 1'b0;
    vectors++;
    if (cpu_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL cpu_rd_early: got %h want 00", cpu_rdata);
    end
    tick();
    vectors++;
    if (cpu_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL cpu_rd_data: got %h want a5", cpu_rdata);
    end
    tick();
  endtask

  task automatic test_vector_window();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFFFC; cpu_wdata = 8'h34;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 13'hF0C) begin
      miscompares++;
      $display("FAIL vec_wr_addr: got en=%b addr=%h want 1/f0c",
               mem_en, mem_addr);
    end
    tick();
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'hFFFC;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 13'hF0C) begin
      miscompares++;
      $display("FAIL vec_dbg_port: got en=%b we=%b addr=%h want 1/0/f0c",
               mem_en, mem_we, mem_addr);
    end
    tick();
    vectors++;
    if (dbg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL vec_ack_early: got %b want 0", dbg_ack);
    end
    tick();
    vectors++;
    if (dbg_ack !== 1'b1 || dbg_rdata !== 8'h34) begin
      miscompares++;
      $display("FAIL vec_dbg_rd: got ack=%b data=%h want 1/34",
               dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    tick();
    vectors++;
    if (dbg_ack !== 1'b0 || dbg_rdata !== 8'h34) begin
      miscompares++;
      $display("FAIL vec_ack_pulse: got ack=%b data=%h want 0/34",
               dbg_ack, dbg_rdata);
    end
    tick();
  endtask

  task automatic test_unmapped();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h77;
    settle();
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL unm_wr_en: got %b want 0", mem_en);
    end
    tick();
    cpu_we = 1'b0;
    settle();
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL unm_rd_en: got %b want 0", mem_en);
    end
    tick();
    cpu_req = 1'b0;
    tick();
    vectors++;
    if (cpu_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL unm_rd_data: got %h want 00", cpu_rdata);
    end
    tick();
  endtask

  task automatic test_collision();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFC;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0010;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 13'hF0C) begin
      miscompares++;
      $display("FAIL col_cpu_wins: got en=%b addr=%h want 1/f0c",
               mem_en, mem_addr);
    end
    tick();
    cpu_req = 1'b0;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 13'h010) begin
      miscompares++;
      $display("FAIL col_dbg_retry: got en=%b addr=%h want 1/010",
               mem_en, mem_addr);
    end
    tick();
    vectors++;
    if (cpu_rdata !== 8'h34 || dbg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL col_cpu_data: got data=%h ack=%b want 34/0",
               cpu_rdata, dbg_ack);
    end
    tick();
    vectors++;
    if (dbg_ack !== 1'b1 || dbg_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL col_dbg_data: got ack=%b data=%h want 1/a5",
               dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_halt();
    logic [7:0] v;
    logic       a;
    dbg_halt = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0001; cpu_wdata = 8'h5A;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_edge_cpu: got en=%b we=%b halted=%b want 1/1/0",
               mem_en, mem_we, halted);
    end
    tick();
    cpu_addr = 16'h0000; cpu_wdata = 8'h11;
    settle();
    vectors++;
    if (halted !== 1'b1 || cpu_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_state: got halted=%b rdy=%b want 1/0",
               halted, cpu_rdy);
    end
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_cpu_ignored: got en=%b want 0", mem_en);
    end
    tick();
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0100; dbg_wdata = 8'h01;
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'h100) begin
      miscompares++;
      $display("FAIL b2b_wr0: got en=%b we=%b addr=%h want 1/1/100",
               mem_en, mem_we, mem_addr);
    end
    tick();
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap1: got en=%b want 0", mem_en);
    end
    tick();
    vectors++;
    if (dbg_ack !== 1'b1 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ack0: got ack=%b en=%b want 1/0", dbg_ack, mem_en);
    end
    dbg_addr = 16'h0101; dbg_wdata = 8'h02;
    tick();
    settle();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 13'h101 || mem_wdata !== 8'h02) begin
      miscompares++;
      $display("FAIL b2b_wr1: got en=%b addr=%h wd=%h want 1/101/02",
               mem_en, mem_addr, mem_wdata);
    end
    dbg_halt = 1'b0;
    tick();
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL unhalt_wait: got halted=%b want 1", halted);
    end
    tick();
    vectors++;
    if (dbg_ack !== 1'b1 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL unhalt_ack: got ack=%b halted=%b want 1/1",
               dbg_ack, halted);
    end
    dbg_req = 1'b0;
    tick();
    vectors++;
    if (halted !== 1'b0 || cpu_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL unhalt_run: got halted=%b rdy=%b want 0/1",
               halted, cpu_rdy);
    end
    tick();
    cpu_read(16'h0000, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("FAIL halt_wr_dropped: got %h want 00", v);
    end
    cpu_read(16'h0001, v);
    vectors++;
    if (v !== 8'h5A) begin
      miscompares++;
      $display("FAIL halt_edge_wr: got %h want 5a", v);
    end
    cpu_read(16'h0100, v);
    vectors++;
    if (v !== 8'h01) begin
      miscompares++;
      $display("FAIL b2b_rd0: got %h want 01", v);
    end
    tick();
    dbg_read(16'h0101, v, a);
    vectors++;
    if (v !== 8'h02 || a !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_rd1: got data=%h ack=%b want 02/1", v, a);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0001;
    settle();
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_issue: got en=%b want 1", mem_en);
    end
    tick();
    dbg_req = 1'b0;
    reset = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    settle();
    vectors++;
    if (dbg_ack !== 1'b0 || dbg_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rmid_dbg: got ack=%b data=%h want 0/00",
               dbg_ack, dbg_rdata);
    end
    vectors++;
    if (cpu_rdata !== 8'h00 || halted !== 1'b0 || cpu_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_cpu: got data=%h halted=%b rdy=%b want 00/0/1",
               cpu_rdata, halted, cpu_rdy);
    end
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_mem_en: got %b want 0", mem_en);
    end
    reset = 1'b0;
    cpu_req = 1'b0;
    tick();
    vectors++;
    if (dbg_ack !== 1'b0 || dbg_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rmid_late_ack: got ack=%b data=%h want 0/00",
               dbg_ack, dbg_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_vector_window();
    test_unmapped();
    test_collision();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
